// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: fetch FSM encoding, datapath width and the
// opcode constants used by the decoder and the fetch bench.
package cpu_defs_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_J   = 6'h2;
  localparam logic [5:0] OP_JAL = 6'h3;
  localparam logic [5:0] OP_BEQ = 6'h4;
  localparam logic [5:0] OP_BNE = 6'h5;

  typedef enum logic [2:0] {
    ST_START,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } ifetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the retiring instruction: taken branch, jr, j/jal
// or fall-through, plus a misalignment flag on the chosen address.
module next_pc_sel
  import cpu_defs_pkg::*;
(
  input  logic [WORD_W-1:0] pc_plus4,
  input  logic [25:0]       target,
  input  logic              Branch,
  input  logic              nBranch,
  input  logic              Jmp,
  input  logic              Jal,
  input  logic              Jr,
  input  logic              Zero,
  input  logic [WORD_W-1:0] AddrResult,
  output logic [WORD_W-1:0] next_pc,
  output logic              misaligned
);

  logic taken;

  assign taken = (Branch && Zero) || (nBranch && !Zero);

  // NOTE: next_pc gets a default before the priority chain so no path leaves
  // it unassigned; an incomplete if/else in always_comb infers a latch.
  always_comb begin
    next_pc = pc_plus4;
    if (taken || Jr) begin
      next_pc = AddrResult;
    end else if (Jmp || Jal) begin
      next_pc = {pc_plus4[31:28], target, 2'b00};
    end
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: PC register, one-outstanding ROM fetch FSM and a
// valid/ready hold of the fetched instruction until it retires.
module cpu_ifetch
  import cpu_defs_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_RESET = 32'h0000_0000,
  parameter int                IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [WORD_W-1:0]  imem_rdata,
  output logic [WORD_W-1:0]  instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [WORD_W-1:0]  pc,
  output logic [WORD_W-1:0]  pc_plus4,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               Zero,
  input  logic [WORD_W-1:0]  AddrResult,
  output logic               fault
);

  ifetch_state_t     state, state_nx;
  logic [WORD_W-1:0] next_pc;
  logic              misaligned;
  logic              retire;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc[IMEM_AW+1:2];
  assign instr_valid = (state == ST_HOLD);
  assign retire      = instr_valid && instr_ready;

  next_pc_sel u_next_pc_sel (
    .pc_plus4   (pc_plus4),
    .target     (instr[25:0]),
    .Branch     (Branch),
    .nBranch    (nBranch),
    .Jmp        (Jmp),
    .Jal        (Jal),
    .Jr         (Jr),
    .Zero       (Zero),
    .AddrResult (AddrResult),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_START: state_nx = ST_REQ;
      ST_REQ:   state_nx = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_nx = ST_HOLD;
      ST_HOLD:  if (retire) state_nx = misaligned ? ST_FAULT : ST_REQ;
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_START;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_START;
      pc       <= PC_RESET;
      instr    <= '0;
      imem_req <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state <= state_nx;
      // Request is registered from the next state so it is a clean pulse in REQ.
      imem_req <= (state_nx == ST_REQ);
      if (state == ST_WAIT && imem_rvalid) instr <= imem_rdata;
      if (retire && !misaligned) pc <= next_pc;
      if (retire && misaligned) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Scoreboard bench for cpu_ifetch: directed scenarios then randomized
// control flow, checked against an architectural PC/ROM model.
module tb_cpu_ifetch;
  import cpu_defs_pkg::*;

  typedef struct packed {
    logic br, nbr, jmp, jal, jr, zero;
  } ctl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc, pc_plus4;
  logic        Branch = 0, nBranch = 0, Jmp = 0, Jal = 0, Jr = 0, Zero = 0;
  logic [31:0] AddrResult = '0;
  logic        fault;

  cpu_ifetch #(.PC_RESET(32'h0000_0000), .IMEM_AW(14)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_plus4(pc_plus4), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp),
    .Jal(Jal), .Jr(Jr), .Zero(Zero), .AddrResult(AddrResult), .fault(fault)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_req = -1;
  int          req_count = 0;
  bit          period_chk = 0;
  bit          spurious = 0;
  bit          faulted = 0;
  int          rom_lat = 1;
  logic [31:0] model_pc = '0;
  logic [31:0] rom_ovr [logic [13:0]];
  logic [13:0] addr_q [$];
  exp_t        exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    if (rom_ovr.exists(a)) return rom_ovr[a];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic ctl_t mk(input logic br, nbr, jmp, jal, jr, z);
    return '{br, nbr, jmp, jal, jr, z};
  endfunction

  task automatic push_expect(input logic [31:0] p);
    addr_q.push_back(p[15:2]);
    exp_q.push_back('{pc: p, instr: rom_word(p[15:2])});
  endtask

  task automatic drive_ctl(input ctl_t c);
    Branch = c.br; nBranch = c.nbr; Jmp = c.jmp; Jal = c.jal; Jr = c.jr; Zero = c.zero;
  endtask

  task automatic drive_junk();
    drive_ctl(ctl_t'(6'($urandom)));
    AddrResult = $urandom;
  endtask

  always @(posedge clock) cyc++;

  // ROM: answers each request after rom_lat cycles; optional stray rvalid when idle.
  initial begin
    int          resp_cnt = 0;
    logic [13:0] req_addr = '0;
    forever begin
      @(negedge clock);
      imem_rvalid = 1'b0;
      if (reset) begin
        resp_cnt = 0;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = rom_word(req_addr);
        end
      end else if (spurious && $urandom_range(0, 2) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end
      if (imem_req && !reset) begin
        req_addr = imem_addr;
        resp_cnt = rom_lat;
      end
    end
  end

  // Request monitor: every pulse must match the next expected fetch address.
  initial begin
    forever begin
      @(negedge clock);
      if (imem_req) begin
        req_count++;
        check("req_pending", 32'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) check("imem_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
        if (period_chk && last_req >= 0) check("req_period", cyc - last_req, 3);
        last_req = cyc;
      end
    end
  end

  // Instruction monitor: each new HOLD presents the next expected pc/instr.
  initial begin
    exp_t e;
    bit   prev = 0;
    forever begin
      @(negedge clock);
      if (instr_valid && !prev) begin
        check("hold_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pc", pc, e.pc);
          check("instr", instr, e.instr);
          check("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
      prev = instr_valid;
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 300) begin
      drive_junk();
      @(negedge clock);
      n++;
    end
    check("hold_reached", 32'(instr_valid), 1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_reached", 32'(imem_req), 1);
  endtask

  task automatic retire(input ctl_t c, input logic [31:0] ar, input int stall);
    logic [31:0] pc4, ins, nxt;
    wait_valid();
    if (!instr_valid) return;
    ins = rom_word(model_pc[15:2]);
    pc4 = model_pc + 32'd4;
    for (int i = 0; i < stall; i++) begin
      drive_junk();
      @(negedge clock);
    end
    if (stall > 0) begin
      check("stall_valid", 32'(instr_valid), 1);
      check("stall_pc", pc, model_pc);
      check("stall_instr", instr, ins);
    end
    if ((c.br && c.zero) || (c.nbr && !c.zero) || c.jr) nxt = ar;
    else if (c.jmp || c.jal) nxt = {pc4[31:28], ins[25:0], 2'b00};
    else nxt = pc4;
    drive_ctl(c);
    AddrResult  = ar;
    instr_ready = 1'b1;
    if (nxt[1:0] != 2'b00) faulted = 1;
    else begin
      model_pc = nxt;
      push_expect(nxt);
    end
    @(negedge clock);
    instr_ready = 1'b0;
    drive_junk();
  endtask

  task automatic do_reset();
    int n = 0;
    #2 reset = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_fault", 32'(fault), 0);
    exp_q.delete();
    addr_q.delete();
    model_pc = 32'h0000_0000;
    faulted  = 0;
    last_req = -1;
    repeat (2) @(negedge clock);
    push_expect(model_pc);
    reset = 1'b0;
    while (!imem_req && n < 4) begin
      @(negedge clock);
      n++;
    end
    check("restart_req", 32'(imem_req), 1);
  endtask

  initial begin
    ctl_t        c;
    logic [31:0] ar;
    int          r0;
    reset = 1'b1;
    rom_ovr[14'd2] = {OP_J, 26'h000_0100};
    rom_ovr[14'd4] = {OP_BEQ, 5'd1, 5'd2, 16'h000C};
    do_reset();

    // Sequential fetch with a 1-cycle ROM at full rate.
    period_chk = 1;
    repeat (4) retire('0, '0, 0);
    wait_req();
    period_chk = 0;

    // beq taken / not taken at 0x10.
    retire(mk(1, 0, 0, 0, 0, 1), 32'h40, 0);
    wait_req();
    check("beq_taken_addr", 32'(imem_addr), 32'h10);
    retire(mk(0, 0, 0, 0, 1, 0), 32'h10, 0);
    retire(mk(1, 0, 0, 0, 0, 0), 32'h40, 0);
    wait_valid();
    check("beq_not_taken_pc", pc, 32'h14);

    // j and jal from 0x1000_0008.
    retire(mk(0, 0, 0, 0, 1, 0), 32'h1000_0008, 0);
    retire(mk(0, 0, 1, 0, 0, 0), '0, 0);
    wait_valid();
    check("j_pc", pc, 32'h1000_0400);
    retire(mk(0, 0, 0, 0, 1, 0), 32'h1000_0008, 0);
    wait_valid();
    check("jal_pc_plus4", pc_plus4, 32'h1000_000C);
    retire(mk(0, 0, 0, 1, 0, 0), '0, 0);
    wait_valid();
    check("jal_pc", pc, 32'h1000_0400);

    // PC wrap at the top of the address space.
    retire(mk(0, 0, 0, 0, 1, 0), 32'hFFFF_FFFC, 0);
    retire('0, '0, 0);
    wait_valid();
    check("wrap_pc", pc, 32'h0);

    // Long stall, slow ROM with a single request, stray rvalid while holding.
    retire('0, '0, 10);
    rom_lat = 5;
    r0 = req_count;
    retire('0, '0, 0);
    wait_valid();
    check("slow_rom_req_once", req_count - r0, 1);
    rom_lat = 1;
    spurious = 1;
    retire('0, '0, 6);
    spurious = 0;

    // Misaligned jr target traps and stays trapped.
    retire(mk(0, 0, 0, 0, 1, 0), 32'h0000_0022, 0);
    repeat (4) begin
      check("fault_req", 32'(imem_req), 0);
      @(negedge clock);
    end
    check("fault_flag", 32'(fault), 1);
    check("fault_valid", 32'(instr_valid), 0);
    check("fault_pc", pc, model_pc);
    @(negedge clock);
    do_reset();

    // Reset asserted while waiting on a slow ROM.
    retire('0, '0, 0);
    retire('0, '0, 0);
    rom_lat = 5;
    retire('0, '0, 0);
    wait_req();
    @(negedge clock);
    do_reset();
    rom_lat = 1;

    // Randomized control flow with random ROM latency and stalls.
    spurious = 1;
    for (int k = 0; k < 150; k++) begin
      rom_lat = $urandom_range(1, 4);
      case ($urandom_range(0, 7))
        0, 1:    c = '0;
        2:       c = mk(1, 0, 0, 0, 0, 1'($urandom));
        3:       c = mk(0, 1, 0, 0, 0, 1'($urandom));
        4:       c = mk(0, 0, 0, 0, 1, 1'($urandom));
        5:       c = mk(0, 0, 1, 0, 0, 1'($urandom));
        6:       c = mk(0, 0, 0, 1, 0, 1'($urandom));
        default: c = ctl_t'(6'($urandom));
      endcase
      ar = $urandom;
      ar[1:0] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      retire(c, ar, $urandom_range(0, 3));
      if (faulted) begin
        repeat (2) @(negedge clock);
        check("rand_fault", 32'(fault), 1);
        check("rand_fault_valid", 32'(instr_valid), 0);
        check("rand_fault_pc", pc, model_pc);
        @(negedge clock);
        do_reset();
      end
    end
    spurious = 0;
    wait_valid();
    check("final_pc", pc, model_pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
